// File: rtl/a5_1_stream_decrypt.sv
// A5/1 keystream decryptor: loads key and frame, runs majority-clocked warm-up,
// then XORs each accepted ciphertext byte with the next 8 keystream bits.
module a5_1_stream_decrypt #(
    parameter int WARMUP = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy
);

    localparam int CNT_W = (WARMUP > 64) ? $clog2(WARMUP) + 1 : 7;
    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(63);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(21);
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0] GEN_LAST   = CNT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_KEY, S_LOAD_FRAME, S_WARMUP, S_WAIT_IN, S_GEN, S_OUT
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [18:0]       r1_reg;
    logic [21:0]       r2_reg;
    logic [22:0]       r3_reg;
    logic [63:0]       key_sh_reg;
    logic [21:0]       frame_sh_reg;
    logic [7:0]        data_reg;
    logic [6:0]        ks_reg;
    logic [7:0]        out_data_reg;

    logic take_start, take_byte, gen_done, counting;
    logic load_en, maj_en, load_bit, maj_bit, ks_bit;
    logic step1, step2, step3;
    logic fb1, fb2, fb3;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; start wins over a byte offered in the same cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:       if (start) state_next = S_LOAD_KEY;
            S_LOAD_KEY:   if (cnt_reg == KEY_LAST) state_next = S_LOAD_FRAME;
            S_LOAD_FRAME: if (cnt_reg == FRAME_LAST)
                              state_next = (WARMUP == 0) ? S_WAIT_IN : S_WARMUP;
            S_WARMUP:     if (cnt_reg == WARM_LAST) state_next = S_WAIT_IN;
            S_WAIT_IN: begin
                if (start)         state_next = S_LOAD_KEY;
                else if (in_valid) state_next = S_GEN;
            end
            S_GEN:        if (cnt_reg == GEN_LAST) state_next = S_OUT;
            S_OUT:        if (out_ready) state_next = S_WAIT_IN;
            default:      state_next = S_IDLE;
        endcase
    end

    // Outputs and datapath controls decoded from the current state
    always_comb begin
        in_ready   = (state_reg == S_WAIT_IN);
        out_valid  = (state_reg == S_OUT);
        busy       = (state_reg == S_LOAD_KEY) || (state_reg == S_LOAD_FRAME) ||
                     (state_reg == S_WARMUP);
        out_data   = out_data_reg;
        take_start = start && ((state_reg == S_IDLE) || (state_reg == S_WAIT_IN));
        take_byte  = (state_reg == S_WAIT_IN) && in_valid && !start;
        gen_done   = (state_reg == S_GEN) && (cnt_reg == GEN_LAST);
        counting   = busy || (state_reg == S_GEN);
        load_en    = (state_reg == S_LOAD_KEY) || (state_reg == S_LOAD_FRAME);
        maj_en     = (state_reg == S_WARMUP) || (state_reg == S_GEN);
        load_bit   = 1'b0;
        if (state_reg == S_LOAD_KEY)   load_bit = key_sh_reg[0];
        if (state_reg == S_LOAD_FRAME) load_bit = frame_sh_reg[0];
    end

    // Register feedback, majority vote and keystream tap (all from pre-step contents)
    always_comb begin
        fb1     = r1_reg[13] ^ r1_reg[16] ^ r1_reg[17] ^ r1_reg[18] ^ load_bit;
        fb2     = r2_reg[20] ^ r2_reg[21] ^ load_bit;
        fb3     = r3_reg[7] ^ r3_reg[20] ^ r3_reg[21] ^ r3_reg[22] ^ load_bit;
        maj_bit = (r1_reg[8] & r2_reg[10]) | (r1_reg[8] & r3_reg[10]) |
                  (r2_reg[10] & r3_reg[10]);
        ks_bit  = r1_reg[18] ^ r2_reg[21] ^ r3_reg[22];
        step1   = load_en || (maj_en && (r1_reg[8]  == maj_bit));
        step2   = load_en || (maj_en && (r2_reg[10] == maj_bit));
        step3   = load_en || (maj_en && (r3_reg[10] == maj_bit));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            r1_reg       <= '0;
            r2_reg       <= '0;
            r3_reg       <= '0;
            key_sh_reg   <= '0;
            frame_sh_reg <= '0;
            data_reg     <= '0;
            ks_reg       <= '0;
            out_data_reg <= '0;
        end else begin
            if (!counting || (state_next != state_reg)) cnt_reg <= '0;
            else                                        cnt_reg <= cnt_reg + 1'b1;

            if (take_start) begin
                key_sh_reg   <= key;
                frame_sh_reg <= frame;
                r1_reg       <= '0;
                r2_reg       <= '0;
                r3_reg       <= '0;
            end else begin
                if (state_reg == S_LOAD_KEY)   key_sh_reg   <= key_sh_reg >> 1;
                if (state_reg == S_LOAD_FRAME) frame_sh_reg <= frame_sh_reg >> 1;
                if (step1) r1_reg <= {r1_reg[17:0], fb1};
                if (step2) r2_reg <= {r2_reg[20:0], fb2};
                if (step3) r3_reg <= {r3_reg[21:0], fb3};
            end

            // First keystream bit of a byte ends up in bit 7
            if (state_reg == S_GEN) ks_reg <= {ks_reg[5:0], ks_bit};
            if (take_byte) data_reg <= in_data;
            if (gen_done)  out_data_reg <= data_reg ^ {ks_reg, ks_bit};
        end
    end

endmodule

// File: tb/tb_a5_1_stream_decrypt.sv
// Bench for a5_1_stream_decrypt: table vectors plus random sessions checked
// against a bit-array model of the A5/1 generator.
module tb_a5_1_stream_decrypt;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [63:0] key;
    logic [21:0] frame;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, busy;
    logic [7:0]  out_data;

    int npass = 0;
    int ntotal = 0;

    a5_1_stream_decrypt #(.WARMUP(100)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .frame(frame),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    // Reference generator: three registers as plain bit arrays
    bit mr [3][23];

    function automatic int len_of(int i);
        return (i == 0) ? 19 : ((i == 1) ? 22 : 23);
    endfunction

    function automatic int clkbit_of(int i);
        return (i == 0) ? 8 : 10;
    endfunction

    function automatic bit taps_of(int i);
        case (i)
            0:       return mr[0][13] ^ mr[0][16] ^ mr[0][17] ^ mr[0][18];
            1:       return mr[1][20] ^ mr[1][21];
            default: return mr[2][7] ^ mr[2][20] ^ mr[2][21] ^ mr[2][22];
        endcase
    endfunction

    task automatic m_step(input bit all_step, input bit lb);
        int votes;
        bit m, fb;
        votes = int'(mr[0][8]) + int'(mr[1][10]) + int'(mr[2][10]);
        m = (votes >= 2);
        for (int i = 0; i < 3; i++) begin
            if (all_step || (mr[i][clkbit_of(i)] == m)) begin
                fb = taps_of(i) ^ lb;
                for (int j = len_of(i) - 1; j > 0; j--) mr[i][j] = mr[i][j-1];
                mr[i][0] = fb;
            end
        end
    endtask

    task automatic m_load(input logic [63:0] k, input logic [21:0] f);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 23; j++) mr[i][j] = 1'b0;
        for (int i = 0; i < 64; i++)  m_step(1'b1, k[i]);
        for (int i = 0; i < 22; i++)  m_step(1'b1, f[i]);
        for (int i = 0; i < 100; i++) m_step(1'b0, 1'b0);
    endtask

    task automatic m_byte(output logic [7:0] b);
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            b = {b[6:0], mr[0][18] ^ mr[1][21] ^ mr[2][22]};
            m_step(1'b0, 1'b0);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Start a session, optionally offering a byte alongside start and pulsing
    // a stray start during warm-up; checks load timing.
    task automatic begin_session(input logic [63:0] k, input logic [21:0] f,
                                 input bit with_valid, input bit warm_pulse);
        int cyc, nb;
        key = k; frame = f; start = 1'b1;
        if (with_valid) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
        end
        tick();
        start = 1'b0; in_valid = 1'b0;
        m_load(k, f);
        check("busy_after_start", 64'(busy), 64'd1);
        check("in_ready_after_start", 64'(in_ready), 64'd0);
        cyc = 1; nb = 0;
        while (!in_ready && cyc < 400) begin
            if (busy) nb++;
            if (warm_pulse && cyc == 120) begin
                start = 1'b1;
                key   = ~k;
            end
            tick();
            start = 1'b0; key = k;
            cyc++;
        end
        check("in_ready_cycle", 64'(cyc), 64'd187);
        check("busy_cycles", 64'(nb), 64'd186);
        $display("session key=%016h frame=%06h ready_at=%0d busy=%0d", k, f, cyc, nb);
    endtask

    task automatic xfer(input logic [7:0] din, input logic [7:0] exp,
                        input int stall, input bit out_pulse);
        int cyc, lat;
        bit stable;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = din;
        tick();
        in_valid = 1'b0; in_data = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'd9);
        check("out_data", 64'(out_data), 64'(exp));
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            if (out_pulse && s == stall / 2) begin
                start = 1'b1;
                key   = {$urandom, $urandom};
            end
            tick();
            start = 1'b0;
            if (!out_valid || out_data !== exp) stable = 1'b0;
        end
        if (stall > 0) check("hold_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        $display("byte in=%02h out=%02h exp=%02h lat=%0d stall=%0d", din, out_data, exp, lat, stall);
    endtask

    initial begin
        vec_t        zt [2];
        logic [7:0]  ks, pt, ct;
        logic [63:0] k;
        logic [21:0] f;
        logic [7:0]  pts [8];

        zt[0] = '{din: 8'hA5, exp: 8'hA5};
        zt[1] = '{din: 8'h3C, exp: 8'h3C};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        key = '0; frame = '0; in_data = '0;
        tick(); tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // All-zero key and frame give an all-zero keystream
        begin_session(64'd0, 22'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) xfer(zt[i].din, zt[i].exp, 0, 1'b0);

        // Golden vector
        begin_session(64'h0123456789ABCDEF, 22'h134, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            m_byte(ks);
            xfer(8'h00, ks, (i == 3) ? 5 : 0, 1'b0);
        end

        // Round trip with a long stall and a stray start during OUT
        begin_session(64'h0123456789ABCDEF, 22'h134, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pts[i] = 8'($urandom);
            m_byte(ks);
            ct = pts[i] ^ ks;
            xfer(ct, pts[i], (i == 0) ? 20 : ((i == 2) ? 6 : 0), (i == 2));
        end

        // Re-key from WAIT_IN with a byte offered; stray start in warm-up
        k = {$urandom, $urandom}; f = 22'($urandom);
        begin_session(k, f, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pt = 8'($urandom);
            m_byte(ks);
            xfer(pt, pt ^ ks, int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset in the middle of key loading, start held through reset
        key = {$urandom, $urandom}; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 49; i++) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        check_idle("rst_load");
        tick();
        check("rst_start_ignored", 64'(busy), 64'd0);
        rst = 1'b0;
        k = {$urandom, $urandom}; f = 22'($urandom);
        begin_session(k, f, 1'b0, 1'b0);
        pt = 8'($urandom);
        m_byte(ks);
        xfer(pt, pt ^ ks, 0, 1'b0);

        // Reset in the 4th GEN cycle
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        check_idle("rst_gen");
        rst = 1'b0;
        tick();
        check_idle("post_rst_gen");

        // Fresh sessions with random data and stalls
        for (int s = 0; s < 3; s++) begin
            k = {$urandom, $urandom}; f = 22'($urandom);
            begin_session(k, f, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) begin
                pt = 8'($urandom);
                m_byte(ks);
                xfer(pt, pt ^ ks, int'($urandom_range(0, 3)), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/a5_1_stream_decrypt.md
A5_1_STREAM_DECRYPT -- requirements
Module: a5_1_stream_decrypt

Interface
REQ-001 Parameter WARMUP, default 100: number of majority-clocked mixing cycles whose output is discarded.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to load a new session.
REQ-005 key  input  64  session key, sampled when start is accepted.
REQ-006 frame  input  22  frame number, sampled when start is accepted.
REQ-007 in_valid  input  1  ciphertext byte valid.
REQ-008 in_data  input  8  ciphertext byte.
REQ-009 in_ready  output  1  block can accept a ciphertext byte.
REQ-010 out_valid  output  1  plaintext byte valid.
REQ-011 out_data  output  8  plaintext byte.
REQ-012 out_ready  input  1  downstream accepts the plaintext byte.
REQ-013 busy  output  1  high in LOAD_KEY, LOAD_FRAME and WARMUP.

Function
REQ-014 Registers: R1 is 19 bits with taps 13,16,17,18 and clock bit 8; R2 is 22 bits with taps 20,21 and clock bit 10; R3 is 23 bits with taps 7,20,21,22 and clock bit 10.
REQ-015 Stepping a register: shift left by one; bit 0 = XOR of its taps (plus the load bit during loading).
REQ-016 Keystream bit = R1[18] ^ R2[21] ^ R3[22], computed from register contents before the step.
REQ-017 Majority clocking: m = maj(R1[8], R2[10], R3[10]); each register steps only if its clock bit equals m; at least two registers step every cycle.
REQ-018 FSM states: IDLE, LOAD_KEY, LOAD_FRAME, WARMUP, WAIT_IN, GEN, OUT.
REQ-019 IDLE: start=1 latches key and frame, clears R1, R2 and R3, and enters LOAD_KEY.
REQ-020 LOAD_KEY: lasts 64 cycles; cycle i steps all three registers regardless of majority and XORs key[i] into bit 0 (key[0] first).
REQ-021 LOAD_FRAME: lasts 22 cycles; same as LOAD_KEY using frame[0..21].
REQ-022 WARMUP: lasts WARMUP cycles with majority clocking; output is discarded; then enters WAIT_IN.
REQ-023 Timing: with start accepted at cycle 0 and WARMUP=100, in_ready first rises at cycle 187.
REQ-024 in_ready is 1 only in WAIT_IN; a byte is accepted when in_valid and in_ready are both 1, captured, and the FSM enters GEN.
REQ-025 GEN: lasts 8 cycles with majority clocking; the first keystream bit goes to position 7 and the last to position 0.
REQ-026 GEN completion: out_data = captured byte XOR keystream byte, out_valid rises in the cycle after the 8th GEN cycle, and the FSM enters OUT.
REQ-027 OUT: out_valid and out_data are held stable until out_ready=1; on that handshake the FSM returns to WAIT_IN and in_ready rises the next cycle.
REQ-028 Latency: accept to out_valid is 9 cycles; maximum throughput is one byte per 10 cycles.
REQ-029 The registers do not step in WAIT_IN or OUT, so the keystream is contiguous across bytes regardless of stalls.
REQ-030 start is honoured in IDLE and WAIT_IN (re-key) and ignored in all other states.
REQ-031 If start and in_valid are both 1 in WAIT_IN, start wins and the byte is not accepted.
REQ-032 out_data holds its last value when out_valid=0.

Reset
REQ-033 rst=1 at any edge, mid-load or mid-byte included, forces IDLE and clears R1, R2, R3, all counters and latched key/frame.
REQ-034 During and after reset, in_ready=0, out_valid=0, out_data=8'h00 and busy=0.
REQ-035 rst has priority over start and over both handshakes.

Verification
REQ-036 Zero key: key=0, frame=0, start -> busy high for 186 cycles, in_ready at cycle 187; bytes 8'hA5 and 8'h3C return unchanged (all-zero keystream).
REQ-037 Golden model: key=64'h0123456789ABCDEF, frame=22'h134, 16 bytes of 8'h00 -> out_data matches the bit-exact software model of REQ-014 to REQ-025, byte for byte.
REQ-038 Round trip: ciphertext from the model, fed back in with the same key and frame -> original plaintext; out_ready held low for 20 cycles, with out_data stable throughout.
REQ-039 Re-key: start with a new key in WAIT_IN together with in_valid=1 -> byte not accepted, reload runs for 186 cycles, output matches the model for the new key.
REQ-040 Reset: rst asserted in cycle 50 of LOAD_KEY, then in the 4th GEN cycle -> all outputs 0 next cycle, start ignored only while rst=1, and a fresh session matches the model.
REQ-041 Ignored start: start pulsed during WARMUP and during OUT -> no effect, keystream unchanged versus the model.
